mux_pipe_stage: RTL and testbench

Parametrised, registered N:1 select stage for the pipelined datapath. It generalises the 5-bit two-input register-destination select to NUM_IN channels of WIDTH bits. The selected word is registered behind a valid/ready handshake with a two-entry skid buffer, so a pipeline stall never drops or duplicates a word. The stage sits between the ID/EX select points and the next pipeline register, and supports flush for branch and exception squash.

---
 rtl/mux_pipe_stage_if.sv | 38 +++
 rtl/mux_pipe_stage.sv | 136 +++++++++++++
 tb/tb_mux_pipe_stage.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux_pipe_stage_if.sv
// mux_pipe_stage_if: handshake and data bundle for the registered N:1 select stage.
//   in_bus    NUM_IN*WIDTH  channel k at [k*WIDTH +: WIDTH]
//   sel       SEL_W         channel index, sampled with in_valid
//   in_valid / in_ready     upstream handshake
//   out_data  WIDTH         word at the head of the stage
//   out_valid / out_ready   downstream handshake
//   flush     1             synchronous squash of all held words
//   err       1             sticky select-range error
// master: the side feeding the stage and consuming its output; slave: the stage.
interface mux_pipe_stage_if #(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = 2
) ();

    localparam int unsigned BUS_W = NUM_IN * WIDTH;

    logic [BUS_W-1:0] in_bus;
    logic [SEL_W-1:0] sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             flush;
    logic             err;

    modport master (
        output in_bus, sel, in_valid, out_ready, flush,
        input  in_ready, out_data, out_valid, err
    );

    modport slave (
        input  in_bus, sel, in_valid, out_ready, flush,
        output in_ready, out_data, out_valid, err
    );

endinterface

// File: rtl/mux_pipe_stage.sv
// mux_pipe_stage: registered N:1 select with a two-entry skid buffer.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   pipe  mux_pipe_stage_if.slave (in_bus/sel/in_valid/in_ready,
//         out_data/out_valid/out_ready, flush, err)
// Optional feature: define MUX_PIPE_SEL_CHECK_EN to capture zero and raise a
// sticky err on an out-of-range sel; otherwise out-of-range selects channel 0
// and err is tied low.
module mux_pipe_stage #(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = 2
) (
    input logic              clk,
    input logic              rst,
    mux_pipe_stage_if.slave  pipe
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;

    logic [WIDTH-1:0] word_c;
    logic             sel_ok_c;
    logic             in_fire_c;
    logic             out_fire_c;

    // Channel select; sel_ok_c flags an index that names a real channel.
    always_comb begin
        word_c   = '0;
        sel_ok_c = 1'b0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (pipe.sel == SEL_W'(k)) begin
                word_c   = pipe.in_bus[k*WIDTH +: WIDTH];
                sel_ok_c = 1'b1;
            end
        end
`ifndef MUX_PIPE_SEL_CHECK_EN
        if (!sel_ok_c) begin
            word_c = pipe.in_bus[WIDTH-1:0];
        end
`endif
    end

    // Ready depends only on the state register, never on out_ready.
    assign pipe.in_ready  = (state_q != ST_FULL);
    assign pipe.out_valid = (state_q != ST_EMPTY);
    assign pipe.out_data  = main_q;

    assign in_fire_c  = pipe.in_valid && (state_q != ST_FULL);
    assign out_fire_c = (state_q != ST_EMPTY) && pipe.out_ready;

    // Next-state and storage steering.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (in_fire_c) begin
                    main_d  = word_c;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire_c && out_fire_c) begin
                    main_d = word_c;
                end else if (in_fire_c) begin
                    skid_d  = word_c;
                    state_d = ST_FULL;
                end else if (out_fire_c) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire_c) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        // Squash: held words become invalid, data registers keep their contents.
        if (pipe.flush) begin
            state_d = ST_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef MUX_PIPE_SEL_CHECK_EN
    logic err_q, err_d;

    // Sticky until reset; flush leaves it alone.
    always_comb begin
        err_d = err_q;
        if (in_fire_c && !sel_ok_c) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign pipe.err = err_q;
`else
    assign pipe.err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_pipe_stage.sv
// tb_mux_pipe_stage: directed and random checks of mux_pipe_stage.
//   a: WIDTH=5  NUM_IN=4 SEL_W=2  reset, streaming, backpressure, flush
//   b: WIDTH=5  NUM_IN=3 SEL_W=2  out-of-range select handling
//   c: WIDTH=32 NUM_IN=8 SEL_W=3  random valid/ready stalls
module tb_mux_pipe_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    mux_pipe_stage_if #(.WIDTH(5),  .NUM_IN(4), .SEL_W(2)) a_if ();
    mux_pipe_stage_if #(.WIDTH(5),  .NUM_IN(3), .SEL_W(2)) b_if ();
    mux_pipe_stage_if #(.WIDTH(32), .NUM_IN(8), .SEL_W(3)) c_if ();

    mux_pipe_stage #(.WIDTH(5),  .NUM_IN(4), .SEL_W(2)) u_a (.clk(clk), .rst(rst), .pipe(a_if));
    mux_pipe_stage #(.WIDTH(5),  .NUM_IN(3), .SEL_W(2)) u_b (.clk(clk), .rst(rst), .pipe(b_if));
    mux_pipe_stage #(.WIDTH(32), .NUM_IN(8), .SEL_W(3)) u_c (.clk(clk), .rst(rst), .pipe(c_if));

    logic [4:0]  a_q [$];
    logic [31:0] c_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] a_bus(input logic [4:0] c0, input logic [4:0] c1,
                                          input logic [4:0] c2, input logic [4:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    // Scoreboard for a: handshakes decided on the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            a_q.delete();
        end else begin
            if (a_if.out_valid && a_if.out_ready) begin
                if (a_q.size() == 0) chk("a_extra_word", 32'(a_if.out_data), 32'hFFFF_FFFF);
                else                 chk("a_sb", 32'(a_if.out_data), 32'(a_q.pop_front()));
            end
            if (a_if.flush) a_q.delete();
            else if (a_if.in_valid && a_if.in_ready)
                a_q.push_back(a_if.in_bus[int'(a_if.sel)*5 +: 5]);
        end
    end

    // Scoreboard for c.
    always @(negedge clk) begin
        if (rst) begin
            c_q.delete();
        end else begin
            if (c_if.out_valid && c_if.out_ready) begin
                if (c_q.size() == 0) chk("c_extra_word", c_if.out_data, ~c_if.out_data);
                else                 chk("c_sb", c_if.out_data, c_q.pop_front());
            end
            if (c_if.flush) c_q.delete();
            else if (c_if.in_valid && c_if.in_ready)
                c_q.push_back(c_if.in_bus[int'(c_if.sel)*32 +: 32]);
        end
    end

    logic [4:0] b_exp_out;
    logic       b_exp_err;

    initial begin
        a_if.in_bus = '0; a_if.sel = '0; a_if.in_valid = 1'b0; a_if.out_ready = 1'b0; a_if.flush = 1'b0;
        b_if.in_bus = '0; b_if.sel = '0; b_if.in_valid = 1'b0; b_if.out_ready = 1'b0; b_if.flush = 1'b0;
        c_if.in_bus = '0; c_if.sel = '0; c_if.in_valid = 1'b0; c_if.out_ready = 1'b0; c_if.flush = 1'b0;

        // Reset values.
        rst = 1'b1;
        tick(); tick();
        chk("rst_a_out_valid", 32'(a_if.out_valid), 32'd0);
        chk("rst_a_in_ready",  32'(a_if.in_ready),  32'd1);
        chk("rst_a_out",       32'(a_if.out_data),  32'd0);
        chk("rst_a_err",       32'(a_if.err),       32'd0);
        chk("rst_c_in_ready",  32'(c_if.in_ready),  32'd1);
        rst = 1'b0;
        tick();

        // Fill a to FULL, then reset mid-cycle.
        a_if.in_bus = a_bus(5'h11, 5'h12, 5'h13, 5'h14);
        a_if.sel = 2'd0; a_if.in_valid = 1'b1; a_if.out_ready = 1'b0;
        tick(); tick();
        chk("full_a_in_ready",  32'(a_if.in_ready),  32'd0);
        chk("full_a_out_valid", 32'(a_if.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(a_if.out_valid), 32'd0);
        chk("midrst_in_ready",  32'(a_if.in_ready),  32'd1);
        chk("midrst_out",       32'(a_if.out_data),  32'd0);
        tick();
        rst = 1'b0;
        a_if.in_bus = a_bus(5'h01, 5'h02, 5'h15, 5'h04);
        a_if.sel = 2'd2;
        tick();
        chk("post_rst_out",       32'(a_if.out_data),  32'h15);
        chk("post_rst_out_valid", 32'(a_if.out_valid), 32'd1);
        a_if.in_valid = 1'b0; a_if.out_ready = 1'b1;
        tick();

        // Streaming, one word per cycle.
        a_if.in_bus = a_bus(5'h01, 5'h02, 5'h03, 5'h04);
        a_if.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_if.sel = 2'(i);
            chk("stream_in_ready", 32'(a_if.in_ready), 32'd1);
            tick();
            chk("stream_out", 32'(a_if.out_data), 32'(i + 1));
            chk("stream_out_valid", 32'(a_if.out_valid), 32'd1);
        end
        a_if.in_valid = 1'b0;
        tick();
        chk("stream_drained", 32'(a_if.out_valid), 32'd0);

        // Backpressure: 0x0A, 0x0B accepted, 0x0C held off until space frees.
        a_if.out_ready = 1'b0; a_if.sel = 2'd0; a_if.in_valid = 1'b1;
        a_if.in_bus = a_bus(5'h0A, 5'h00, 5'h00, 5'h00);
        tick();
        a_if.in_bus = a_bus(5'h0B, 5'h00, 5'h00, 5'h00);
        tick();
        a_if.in_bus = a_bus(5'h0C, 5'h00, 5'h00, 5'h00);
        chk("bp_in_ready",   32'(a_if.in_ready), 32'd0);
        chk("bp_out_head",   32'(a_if.out_data), 32'h0A);
        tick();
        chk("bp_hold_ready", 32'(a_if.in_ready), 32'd0);
        chk("bp_hold_head",  32'(a_if.out_data), 32'h0A);
        a_if.out_ready = 1'b1;
        tick();
        chk("bp_second",     32'(a_if.out_data), 32'h0B);
        chk("bp_ready_back", 32'(a_if.in_ready), 32'd1);
        tick();
        a_if.in_valid = 1'b0;
        chk("bp_third",      32'(a_if.out_data), 32'h0C);
        tick();
        chk("bp_drained",    32'(a_if.out_valid), 32'd0);

        // Flush in FULL with a word offered.
        a_if.out_ready = 1'b0; a_if.in_valid = 1'b1;
        a_if.in_bus = a_bus(5'h0D, 5'h00, 5'h00, 5'h00);
        tick();
        a_if.in_bus = a_bus(5'h0E, 5'h00, 5'h00, 5'h00);
        tick();
        a_if.flush = 1'b1;
        a_if.in_bus = a_bus(5'h1F, 5'h00, 5'h00, 5'h00);
        tick();
        a_if.flush = 1'b0; a_if.in_valid = 1'b0;
        chk("flush_out_valid", 32'(a_if.out_valid), 32'd0);
        chk("flush_in_ready",  32'(a_if.in_ready),  32'd1);
        a_if.out_ready = 1'b1;
        repeat (3) tick();
        chk("flush_stays_empty", 32'(a_if.out_valid), 32'd0);

        // Flush in ONE with a word offered: the offered word is dropped.
        a_if.out_ready = 1'b0; a_if.in_valid = 1'b1;
        a_if.in_bus = a_bus(5'h0D, 5'h00, 5'h00, 5'h00);
        tick();
        a_if.flush = 1'b1;
        a_if.in_bus = a_bus(5'h1F, 5'h00, 5'h00, 5'h00);
        tick();
        a_if.flush = 1'b0; a_if.in_valid = 1'b0;
        chk("flush1_out_valid", 32'(a_if.out_valid), 32'd0);
        a_if.out_ready = 1'b1;
        tick();
        chk("flush1_stays_empty", 32'(a_if.out_valid), 32'd0);

        // Out-of-range select on the three-channel instance.
`ifdef MUX_PIPE_SEL_CHECK_EN
        b_exp_out = 5'h00; b_exp_err = 1'b1;
`else
        b_exp_out = 5'h07; b_exp_err = 1'b0;
`endif
        b_if.in_bus = {5'h03, 5'h02, 5'h07};
        b_if.sel = 2'd3; b_if.in_valid = 1'b1; b_if.out_ready = 1'b0;
        tick();
        b_if.in_valid = 1'b0;
        chk("range_out_valid", 32'(b_if.out_valid), 32'd1);
        chk("range_out",       32'(b_if.out_data),  32'(b_exp_out));
        chk("range_err",       32'(b_if.err),       32'(b_exp_err));
        b_if.flush = 1'b1;
        tick();
        b_if.flush = 1'b0;
        chk("range_flush_valid", 32'(b_if.out_valid), 32'd0);
        chk("range_err_sticky",  32'(b_if.err),       32'(b_exp_err));
        b_if.sel = 2'd1; b_if.in_valid = 1'b1;
        tick();
        b_if.in_valid = 1'b0;
        chk("range_inrange_out", 32'(b_if.out_data), 32'h02);
        chk("range_inrange_err", 32'(b_if.err),      32'(b_exp_err));

        // Random valid/ready stalls on the wide instance.
        for (int cyc = 0; cyc < 10000; cyc++) begin
            c_if.in_valid  = ($urandom_range(0, 3) != 0);
            c_if.sel       = 3'($urandom_range(0, 7));
            for (int k = 0; k < 8; k++) c_if.in_bus[k*32 +: 32] = $urandom();
            c_if.out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        c_if.in_valid = 1'b0; c_if.out_ready = 1'b1;
        repeat (4) tick();
        chk("c_drain", 32'(c_q.size()), 32'd0);
        chk("a_drain", 32'(a_q.size()), 32'd0);
        chk("c_idle_valid", 32'(c_if.out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
